ps2_keyboard_rx: RTL and testbench

Parametrised PS/2 keyboard receiver. It takes the raw PS2_clk/PS2_DATA pins and synchronises and deglitches them, then frames 11-bit packets with a watchdog timeout. Packets are checked for start, parity and stop errors. Make (plain), extended (E0) and break (F0) sequences are folded into single key events, which are queued in a FIFO with a valid/ready handshake. It sits between the keyboard pins and any consumer (game/UI logic), replacing free-running scan-code outputs with lossless, flow-controlled events.

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_keyboard_rx_if.sv | 26 ++
 rtl/ps2_event_fifo.sv | 65 ++++++
 rtl/ps2_keyboard_rx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   - Scan-code constants for common keys and the two prefix bytes.
//   - key_event_t: one decoded key event {ext, rel, code}.
//   - frame_state_t: states of the 11-bit frame receiver.
//   - is_prefix(): true for bytes that modify the next event instead of
//     producing one.
package ps2_pkg;

    localparam logic [7:0] ARROW_UP    = 8'h75;
    localparam logic [7:0] ARROW_DOWN  = 8'h72;
    localparam logic [7:0] ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] ARROW_RIGHT = 8'h74;
    localparam logic [7:0] SPACE       = 8'h29;
    localparam logic [7:0] PREFIX_EXT  = 8'hE0;
    localparam logic [7:0] PREFIX_BRK  = 8'hF0;

    typedef struct packed {
        logic       ext;   // preceded by E0
        logic       rel;   // preceded by F0 (key up)
        logic [7:0] code;  // scan code with prefixes stripped
    } key_event_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PREFIX_EXT) || (b == PREFIX_BRK);
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: valid/ready key-event stream.
//   key_valid   - head event presented (source -> sink)
//   key_ready   - sink accepts the head event this cycle (sink -> source)
//   key_code    - scan code of the head event
//   key_ext     - head event was E0-prefixed
//   key_release - head event was F0-prefixed
// master = event source (the receiver), slave = event consumer.
interface ps2_keyboard_rx_if;

    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;

    modport master (
        output key_valid, key_code, key_ext, key_release,
        input  key_ready
    );

    modport slave (
        input  key_valid, key_code, key_ext, key_release,
        output key_ready
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word-fall-through FIFO of key_event_t.
//   clk, rst - clock, synchronous active-high reset
//   push/din - write request and data; accepted when not full, or when
//              full and a pop happens in the same cycle
//   pop      - consume head entry; ignored while empty
//   dout     - head entry, forced to zero while empty
//   full, empty - occupancy flags
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  key_event_t din,
    input  logic       pop,
    output key_event_t dout,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    key_event_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset; validity is tracked by count
    // and dout is masked while empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values,
    // independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver producing flow-controlled events.
//   CLK, RST  - system clock, synchronous active-high reset
//   PS2_clk   - raw keyboard clock pin (asynchronous)
//   PS2_DATA  - raw keyboard data pin (asynchronous)
//   key       - event stream (master side): key_valid/key_ready handshake
//               with key_code, key_ext, key_release of the head event
//   frame_err - one-cycle pulse when a frame is discarded
//   overflow  - one-cycle pulse when an event is dropped on a full queue
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic PS2_clk,
    input  logic PS2_DATA,
    ps2_keyboard_rx_if.master key,
    output logic frame_err,
    output logic overflow
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [1:0]   clk_sync, data_sync;
    logic         clk_s, data_s;
    logic [FW-1:0] filt_cnt;
    logic         filt_clk, flip, fall;
    logic [TW-1:0] tmo_cnt;
    logic         timeout;
    frame_state_t state, state_nx;
    logic         done_nx, err_nx;
    logic [2:0]   bit_idx;
    logic [7:0]   shreg;
    logic         par_bit;
    logic         byte_done;
    logic         ext_pend, rel_pend;
    logic         push, full, empty;
    key_event_t   push_evt, head;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], PS2_clk};
            data_sync <= {data_sync[0], PS2_DATA};
        end
    end
    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // Filtered clock follows clk_s only after FILTER_LEN consecutive
    // differing samples; flip marks the cycle in which it changes.
    assign flip = (clk_s != filt_clk) && (filt_cnt == FILT_LAST);
    assign fall = flip && filt_clk;

    always_ff @(posedge CLK) begin
        if (RST) begin
            filt_cnt <= '0;
            filt_clk <= 1'b1;
        end else if (clk_s == filt_clk) begin
            filt_cnt <= '0;
        end else if (flip) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Watchdog: cycles since the last fall while a frame is open.
    assign timeout = (state != ST_IDLE) && (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge CLK) begin
        if (RST || fall || state == ST_IDLE) begin
            tmo_cnt <= '0;
        end else if (!timeout) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        if (timeout) begin
            state_nx = ST_IDLE;
            err_nx   = 1'b1;
        end else if (fall) begin
            unique case (state)
                ST_IDLE:   if (!data_s) state_nx = ST_DATA;
                ST_DATA:   if (bit_idx == 3'd7) state_nx = ST_PARITY;
                ST_PARITY: state_nx = ST_STOP;
                ST_STOP: begin
                    state_nx = ST_IDLE;
                    // Odd parity over data+parity, stop bit must be 1.
                    if (data_s && (^{shreg, par_bit})) done_nx = 1'b1;
                    else                               err_nx  = 1'b1;
                end
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_idx   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= done_nx;
            frame_err <= err_nx;
            if (fall && !timeout) begin
                case (state)
                    ST_IDLE:   bit_idx <= '0;
                    ST_DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                    ST_PARITY: par_bit <= data_s;
                    default:   ;
                endcase
            end
        end
    end

    // Prefix folding: shreg still holds the completed byte while byte_done
    // is high, because it only shifts inside the next frame.
    assign push     = byte_done && !is_prefix(shreg);
    assign push_evt = '{ext: ext_pend, rel: rel_pend, code: shreg};

    always_ff @(posedge CLK) begin
        if (RST || frame_err) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
        end else if (byte_done) begin
            if (shreg == PREFIX_EXT) begin
                ext_pend <= 1'b1;
            end else if (shreg == PREFIX_BRK) begin
                rel_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end
        end
    end

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .din   (push_evt),
        .pop   (key.key_ready),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // A full FIFO is never empty, so key_ready alone decides whether a
    // same-cycle pop frees a slot.
    always_ff @(posedge CLK) begin
        if (RST) overflow <= 1'b0;
        else     overflow <= push && full && !key.key_ready;
    end

    assign key.key_valid   = !empty;
    assign key.key_code    = head.code;
    assign key.key_ext     = head.ext;
    assign key.key_release = head.rel;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: stimulus pushes expected events and
// expected pulse cycles into queues; a negedge monitor pops and compares.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int FIFO_DEPTH     = 8;
    localparam int HALF           = 12;  // PS/2 half bit period in CLK cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic frame_err, overflow;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int last_fall = 0;
    int mon_cyc;
    key_event_t mon_evt;

    key_event_t exp_q[$];
    int         err_q[$];
    int         ovf_q[$];

    ps2_keyboard_rx_if key_bus();

    ps2_keyboard_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .PS2_clk(ps2_clk),
        .PS2_DATA(ps2_data),
        .key(key_bus),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic key_event_t mk(input logic ext, input logic rel, input logic [7:0] code);
        return '{ext: ext, rel: rel, code: code};
    endfunction

    // Monitor: compares every accepted event and every pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_bus.key_valid && key_bus.key_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_event: got %0h, expected no event",
                             {key_bus.key_ext, key_bus.key_release, key_bus.key_code});
                end else begin
                    mon_evt = exp_q.pop_front();
                    check("event", 32'({key_bus.key_ext, key_bus.key_release, key_bus.key_code}),
                          32'(mon_evt));
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_frame_err: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    mon_cyc = err_q.pop_front();
                    check("frame_err_cycle", cyc, mon_cyc);
                end
            end
            if (overflow) begin
                if (ovf_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_overflow: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    mon_cyc = ovf_q.pop_front();
                    check("overflow_cycle", cyc, mon_cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) tick();
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) tick();
        ps2_clk = 1'b1;
    endtask

    // Raw stop-bit fall at cycle t: the DUT acts on it at t+2+FILTER_LEN,
    // so frame_err is seen at t+2+FILTER_LEN and overflow one cycle later.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic exp_ovf);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        ps2_data = 1'b1;
        repeat (HALF) tick();
        ps2_clk = 1'b0;
        if (bad_par) err_q.push_back(cyc + 2 + FILTER_LEN);
        if (exp_ovf) ovf_q.push_back(cyc + 3 + FILTER_LEN);
        repeat (HALF) tick();
        ps2_clk = 1'b1;
        repeat (2 * HALF) tick();
    endtask

    initial begin
        key_bus.key_ready = 1'b0;
        repeat (4) tick();
        check("rst_key_valid", key_bus.key_valid, 0);
        check("rst_key_code", key_bus.key_code, 0);
        check("rst_key_ext", key_bus.key_ext, 0);
        check("rst_key_release", key_bus.key_release, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (4) tick();
        key_bus.key_ready = 1'b1;

        // Plain make
        exp_q.push_back(mk(1'b0, 1'b0, 8'h1C));
        send_frame(8'h1C, 1'b0, 1'b0);
        check("make_drained", exp_q.size(), 0);

        // Extended break folds into one event
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b1, 8'h75));
        send_frame(8'h75, 1'b0, 1'b0);
        check("ext_break_drained", exp_q.size(), 0);

        // Parity error, then a good frame
        send_frame(8'h29, 1'b1, 1'b0);
        check("parity_err_seen", err_q.size(), 0);
        exp_q.push_back(mk(1'b0, 1'b0, 8'h29));
        send_frame(8'h29, 1'b0, 1'b0);
        check("after_parity_drained", exp_q.size(), 0);

        // Timeout after start + 4 data bits
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        err_q.push_back(last_fall + 3 + FILTER_LEN + TIMEOUT_CYCLES);
        ps2_data = 1'b1;
        repeat (TIMEOUT_CYCLES + 10) tick();
        check("timeout_seen", err_q.size(), 0);
        exp_q.push_back(mk(1'b0, 1'b0, 8'h6B));
        send_frame(8'h6B, 1'b0, 1'b0);
        check("after_timeout_drained", exp_q.size(), 0);

        // Backpressure and overflow
        key_bus.key_ready = 1'b0;
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
            if (i <= FIFO_DEPTH) exp_q.push_back(mk(1'b0, 1'b0, 8'(i)));
            send_frame(8'(i), 1'b0, i == FIFO_DEPTH + 1);
        end
        check("ovf_seen", ovf_q.size(), 0);
        check("full_valid", key_bus.key_valid, 1);
        check("full_head_code", key_bus.key_code, 8'h01);
        key_bus.key_ready = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            check("drain_valid", key_bus.key_valid, 1);
            tick();
        end
        check("drain_empty_valid", key_bus.key_valid, 0);
        check("drain_empty_code", key_bus.key_code, 0);
        check("drain_queue", exp_q.size(), 0);

        // Glitches shorter than FILTER_LEN, with data low so a fall would
        // open a frame and later time out
        ps2_data = 1'b0;
        for (int w = 1; w < FILTER_LEN; w++) begin
            ps2_clk = 1'b0;
            repeat (w) tick();
            ps2_clk = 1'b1;
            repeat (10) tick();
        end
        repeat (TIMEOUT_CYCLES + 20) tick();
        ps2_data = 1'b1;
        repeat (10) tick();
        check("glitch_no_err", err_q.size(), 0);
        check("glitch_no_event", key_bus.key_valid, 0);

        // Reset mid-frame with events queued
        key_bus.key_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        check("pre_reset_valid", key_bus.key_valid, 1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        rst = 1'b1;
        ps2_data = 1'b1;
        repeat (3) tick();
        check("mid_reset_valid", key_bus.key_valid, 0);
        check("mid_reset_code", key_bus.key_code, 0);
        rst = 1'b0;
        repeat (4) tick();
        key_bus.key_ready = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 8'h74));
        send_frame(8'h74, 1'b0, 1'b0);
        repeat (10) tick();
        check("final_events", exp_q.size(), 0);
        check("final_errs", err_q.size(), 0);
        check("final_ovf", ovf_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
